// File: rtl/cu_if_pkg.sv
// rtl/cu_if_pkg.sv - shared types, constants and helpers for the instruction-fetch front end
package cu_if_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ISSUE    = 2'd2,
        WAIT_DEC = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/cu_if_if.sv
// rtl/cu_if_if.sv - memory read bus and decode handshake between fetch and its neighbours
interface cu_if_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] Cu_IR;
    logic        decode_start;
    logic        IDU_stall;
    logic        IDU_ready;
    logic [31:0] pc_increment;

    modport master (
        output mem_req, mem_addr, Cu_IR, decode_start,
        input  mem_rdata, mem_ack, IDU_stall, IDU_ready, pc_increment
    );

    modport slave (
        input  mem_req, mem_addr, Cu_IR, decode_start,
        output mem_rdata, mem_ack, IDU_stall, IDU_ready, pc_increment
    );
endinterface

// File: rtl/cu_if_timeout.sv
// rtl/cu_if_timeout.sv - mem_ack watchdog counter for the fetch REQ state
module cu_if_timeout #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // count cycles spent waiting; any exit from the wait restarts from zero
    always_ff @(posedge clk) begin
        if (!resetn || !run) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // fires during the last allowed wait cycle so the exit lands exactly on the limit
    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/cu_if.sv
// rtl/cu_if.sv - instruction fetch front end; optional mem_ack watchdog under CU_IF_FETCH_TIMEOUT_EN
module cu_if
    import cu_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter logic        AUTO_FETCH     = 1'b0,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic          soc_clk,
    input  logic          reset,
    input  logic          fetch_start,
    input  logic          pc_load,
    input  logic [31:0]   pc_in,
    cu_if_if.master       bus,
    output logic [31:0]   fetch_pc,
    output logic          fetch_busy,
    output logic          misaligned_fetch,
    output logic          fetch_timeout
);
    fetch_state_t state;
    fetch_state_t state_nxt;

    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic [31:0] ir_q;
    logic        mis_q;
    logic        redir_q;
    logic [31:0] pc_sum;
    logic        timed_out;

    assign pc_sum = pc_q + bus.pc_increment;

`ifdef CU_IF_FETCH_TIMEOUT_EN
    logic expired;
    logic to_q;

    cu_if_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (soc_clk),
        .resetn  (reset),
        .run     (state == REQ),
        .expired (expired)
    );

    // an ack in the final wait cycle still counts as a normal completion
    assign timed_out = expired && !bus.mem_ack;

    // sticky watchdog flag; a fresh expiry outranks a coincident pc_load clear
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            to_q <= 1'b0;
        end else if (timed_out) begin
            to_q <= 1'b1;
        end else if (pc_load) begin
            to_q <= 1'b0;
        end
    end

    assign fetch_timeout = to_q;
`else
    assign timed_out     = 1'b0;
    assign fetch_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decision
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!pc_load && fetch_start && is_aligned(pc_q)) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (bus.mem_ack) begin
                    state_nxt = (redir_q || pc_load) ? IDLE : ISSUE;
                end else if (timed_out) begin
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                if (pc_load) begin
                    state_nxt = IDLE;
                end else if (!bus.IDU_stall) begin
                    state_nxt = WAIT_DEC;
                end
            end
            WAIT_DEC: begin
                if (bus.IDU_ready) begin
                    state_nxt = (AUTO_FETCH && !pc_load && !redir_q && is_aligned(pc_sum)) ? REQ : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs decoded from the current state
    always_comb begin
        bus.mem_req      = (state == REQ);
        bus.decode_start = (state == ISSUE) && !bus.IDU_stall && !pc_load;
        fetch_busy       = (state != IDLE);
    end

    // PC, request address, instruction register and sticky flags
    always_ff @(posedge soc_clk) begin
        if (!reset) begin
            pc_q    <= RESET_PC;
            addr_q  <= 32'h0;
            ir_q    <= NOP_INSTR;
            mis_q   <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pc_load) begin
                        pc_q  <= pc_in;
                        mis_q <= 1'b0;
                    end else if (fetch_start) begin
                        if (is_aligned(pc_q)) begin
                            addr_q <= pc_q;
                        end else begin
                            mis_q <= 1'b1;
                        end
                    end
                end
                REQ: begin
                    if (pc_load) begin
                        pc_q <= pc_in;
                    end
                    // data returned for a redirected PC is stale and dropped
                    if (bus.mem_ack) begin
                        redir_q <= 1'b0;
                        if (!redir_q && !pc_load) begin
                            ir_q <= bus.mem_rdata;
                        end
                    end else if (timed_out) begin
                        redir_q <= 1'b0;
                    end else if (pc_load) begin
                        redir_q <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (pc_load) begin
                        pc_q <= pc_in;
                    end
                end
                WAIT_DEC: begin
                    if (pc_load) begin
                        pc_q    <= pc_in;
                        redir_q <= !bus.IDU_ready;
                    end else if (bus.IDU_ready) begin
                        redir_q <= 1'b0;
                        if (!redir_q) begin
                            pc_q <= pc_sum;
                            if (AUTO_FETCH) begin
                                if (is_aligned(pc_sum)) begin
                                    addr_q <= pc_sum;
                                end else begin
                                    mis_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.mem_addr      = addr_q;
    assign bus.Cu_IR         = ir_q;
    assign fetch_pc          = pc_q;
    assign misaligned_fetch  = mis_q;
endmodule

// File: tb/tb_cu_if.sv
// tb/tb_cu_if.sv - self-checking bench for cu_if with a behavioural fetch model
module tb_cu_if;
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int          TO  = 16;

    // model phases: what the fetch unit is currently doing for the CU
    localparam int P_IDLE = 0;   // nothing outstanding
    localparam int P_MEM  = 1;   // read outstanding at memory
    localparam int P_HOLD = 2;   // instruction held, not yet handed to decode
    localparam int P_DEC  = 3;   // decode working on it

    logic        clk = 1'b0;
    logic        resetn;
    logic        fetch_start;
    logic        pc_load;
    logic [31:0] pc_in;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic        ready;
    logic [31:0] inc;

    logic [31:0] fpc [2];
    logic        busy [2];
    logic        mis  [2];
    logic        tout [2];

    cu_if_if bus0 ();
    cu_if_if bus1 ();

    assign bus0.mem_rdata = mem_rdata;     assign bus1.mem_rdata = mem_rdata;
    assign bus0.mem_ack = mem_ack;         assign bus1.mem_ack = mem_ack;
    assign bus0.IDU_stall = stall;         assign bus1.IDU_stall = stall;
    assign bus0.IDU_ready = ready;         assign bus1.IDU_ready = ready;
    assign bus0.pc_increment = inc;        assign bus1.pc_increment = inc;

    cu_if #(.RESET_PC(32'h0), .AUTO_FETCH(1'b0), .TIMEOUT_CYCLES(TO)) dut0 (
        .soc_clk(clk), .reset(resetn), .fetch_start(fetch_start), .pc_load(pc_load), .pc_in(pc_in),
        .bus(bus0), .fetch_pc(fpc[0]), .fetch_busy(busy[0]), .misaligned_fetch(mis[0]),
        .fetch_timeout(tout[0]));

    cu_if #(.RESET_PC(32'h0), .AUTO_FETCH(1'b1), .TIMEOUT_CYCLES(TO)) dut1 (
        .soc_clk(clk), .reset(resetn), .fetch_start(fetch_start), .pc_load(pc_load), .pc_in(pc_in),
        .bus(bus1), .fetch_pc(fpc[1]), .fetch_busy(busy[1]), .misaligned_fetch(mis[1]),
        .fetch_timeout(tout[1]));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses0  = 0;
    bit chk      = 1'b0;

    task automatic check(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %h expected %h at %0t", id, name, act, exp, $time);
        end
    endtask

    // behavioural model state, one set per DUT (index 1 is the auto-fetch build)
    int          m_ph   [2];
    logic [31:0] m_pc   [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_ir   [2];
    logic        m_mis  [2];
    logic        m_to   [2];
    logic        m_redir[2];
    int          m_wait [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!resetn) begin
                m_ph[k] = P_IDLE; m_pc[k] = 32'h0; m_addr[k] = 32'h0; m_ir[k] = NOP;
                m_mis[k] = 1'b0; m_to[k] = 1'b0; m_redir[k] = 1'b0; m_wait[k] = 0;
            end else begin
                logic [31:0] nxt;
                if (pc_load) m_to[k] = 1'b0;
                case (m_ph[k])
                    P_IDLE: begin
                        if (pc_load) begin
                            m_pc[k] = pc_in; m_mis[k] = 1'b0;
                        end else if (fetch_start) begin
                            if (m_pc[k] % 4 != 0) m_mis[k] = 1'b1;
                            else begin m_addr[k] = m_pc[k]; m_ph[k] = P_MEM; end
                        end
                    end
                    P_MEM: begin
                        m_wait[k]++;
                        if (mem_ack) begin
                            if (m_redir[k] || pc_load) m_ph[k] = P_IDLE;
                            else begin m_ir[k] = mem_rdata; m_ph[k] = P_HOLD; end
                            m_redir[k] = 1'b0;
                        end
`ifdef CU_IF_FETCH_TIMEOUT_EN
                        else if (m_wait[k] == TO) begin
                            m_to[k] = 1'b1; m_redir[k] = 1'b0; m_ph[k] = P_IDLE;
                        end
`endif
                        else if (pc_load) m_redir[k] = 1'b1;
                        if (pc_load) m_pc[k] = pc_in;
                        if (m_ph[k] != P_MEM) m_wait[k] = 0;
                    end
                    P_HOLD: begin
                        if (pc_load) begin m_pc[k] = pc_in; m_ph[k] = P_IDLE; end
                        else if (!stall) m_ph[k] = P_DEC;
                    end
                    default: begin
                        if (pc_load) begin
                            m_pc[k] = pc_in;
                            if (ready) begin m_redir[k] = 1'b0; m_ph[k] = P_IDLE; end
                            else m_redir[k] = 1'b1;
                        end else if (ready) begin
                            m_ph[k] = P_IDLE;
                            if (m_redir[k]) m_redir[k] = 1'b0;
                            else begin
                                nxt = m_pc[k] + inc;
                                m_pc[k] = nxt;
                                if (k == 1) begin
                                    if (nxt % 4 == 0) begin m_addr[k] = nxt; m_ph[k] = P_MEM; end
                                    else m_mis[k] = 1'b1;
                                end
                            end
                        end
                    end
                endcase
            end
        end
    end

    task automatic cmp(input int k, input logic req, input logic [31:0] addr, input logic [31:0] ir,
                       input logic ds);
        check(k, "mem_req", req, m_ph[k] == P_MEM);
        check(k, "mem_addr", addr, m_addr[k]);
        check(k, "Cu_IR", ir, m_ir[k]);
        check(k, "decode_start", ds, (m_ph[k] == P_HOLD) && !stall && !pc_load);
        check(k, "fetch_pc", fpc[k], m_pc[k]);
        check(k, "fetch_busy", busy[k], m_ph[k] != P_IDLE);
        check(k, "misaligned_fetch", mis[k], m_mis[k]);
        check(k, "fetch_timeout", tout[k], m_to[k]);
    endtask

    // compare DUT outputs against the model mid-cycle
    always @(negedge clk) begin
        if (chk) begin
            cmp(0, bus0.mem_req, bus0.mem_addr, bus0.Cu_IR, bus0.decode_start);
            cmp(1, bus1.mem_req, bus1.mem_addr, bus1.Cu_IR, bus1.decode_start);
            if (bus0.decode_start) pulses0++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int p0;
        resetn = 1'b0; fetch_start = 1'b0; pc_load = 1'b0; pc_in = 32'h0;
        mem_rdata = 32'h0; mem_ack = 1'b0; stall = 1'b0; ready = 1'b0; inc = 32'h0;
        tick(1);
        chk = 1'b1;
        tick(1);
        check(0, "reset fetch_pc", fpc[0], 32'h0);
        check(0, "reset Cu_IR", bus0.Cu_IR, NOP);
        check(0, "reset mem_req", bus0.mem_req, 1'b0);
        resetn = 1'b1;

        // basic fetch, ack three cycles after request
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        check(0, "t1 mem_req", bus0.mem_req, 1'b1);
        check(0, "t1 mem_addr", bus0.mem_addr, 32'h0);
        tick(2);
        mem_ack = 1'b1; mem_rdata = 32'h0050_0093; tick(1); mem_ack = 1'b0;
        check(0, "t1 Cu_IR", bus0.Cu_IR, 32'h0050_0093);
        check(0, "t1 decode_start", bus0.decode_start, 1'b1);
        tick(1);
        check(0, "t1 pulses", pulses0, 1);
        ready = 1'b1; inc = 32'd4; tick(1); ready = 1'b0;
        check(0, "t1 fetch_pc", fpc[0], 32'h4);
        check(0, "t1 busy", busy[0], 1'b0);

        // decode stall held five cycles in ISSUE
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1122_3344; stall = 1'b1; tick(1); mem_ack = 1'b0;
        p0 = pulses0;
        tick(5);
        check(0, "t2 no pulse in stall", pulses0, p0);
        stall = 1'b0;
        tick(1);
        check(0, "t2 one pulse", pulses0, p0 + 1);
        tick(2);
        check(0, "t2 still one pulse", pulses0, p0 + 1);
        ready = 1'b1; tick(1); ready = 1'b0;
        check(0, "t2 fetch_pc", fpc[0], 32'h8);

        // redirect while the read is outstanding
        p0 = pulses0;
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        pc_load = 1'b1; pc_in = 32'h100; tick(1); pc_load = 1'b0;
        tick(1);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(1); mem_ack = 1'b0;
        tick(2);
        check(0, "t3 Cu_IR kept", bus0.Cu_IR, 32'h1122_3344);
        check(0, "t3 no pulse", pulses0, p0);
        check(0, "t3 fetch_pc", fpc[0], 32'h100);
        check(0, "t3 busy", busy[0], 1'b0);

        // misaligned PC refuses to fetch
        pc_load = 1'b1; pc_in = 32'h102; tick(1); pc_load = 1'b0;
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        check(0, "t4 misaligned", mis[0], 1'b1);
        check(0, "t4 mem_req", bus0.mem_req, 1'b0);
        tick(1);
        check(0, "t4 mem_req later", bus0.mem_req, 1'b0);
        pc_load = 1'b1; pc_in = 32'h104; tick(1); pc_load = 1'b0;
        check(0, "t4 misaligned cleared", mis[0], 1'b0);
        check(0, "t4 fetch_pc", fpc[0], 32'h104);

        // PC wrap with auto-fetch
        resetn = 1'b0; tick(2); resetn = 1'b1;
        pc_load = 1'b1; pc_in = 32'hFFFF_FFFC; tick(1); pc_load = 1'b0;
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0513; tick(1); mem_ack = 1'b0;
        tick(1);
        ready = 1'b1; inc = 32'd4; tick(1); ready = 1'b0;
        check(1, "t5 fetch_pc wrap", fpc[1], 32'h0);
        check(1, "t5 mem_req", bus1.mem_req, 1'b1);
        check(1, "t5 mem_addr", bus1.mem_addr, 32'h0);
        check(0, "t5 fetch_pc wrap", fpc[0], 32'h0);
        check(0, "t5 busy", busy[0], 1'b0);

`ifdef CU_IF_FETCH_TIMEOUT_EN
        // ack never arrives
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        tick(15);
        check(0, "t6 mem_req before limit", bus0.mem_req, 1'b1);
        tick(1);
        check(0, "t6 mem_req dropped", bus0.mem_req, 1'b0);
        check(0, "t6 fetch_timeout", tout[0], 1'b1);
        pc_load = 1'b1; pc_in = 32'h0; tick(1); pc_load = 1'b0;
        check(0, "t6 timeout cleared", tout[0], 1'b0);
`endif

        // reset in the middle of a request, ack arrives late
        fetch_start = 1'b1; tick(1); fetch_start = 1'b0;
        check(0, "t7 mem_req", bus0.mem_req, 1'b1);
        resetn = 1'b0; tick(1); resetn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; tick(1); mem_ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check(k, "t7 fetch_pc", fpc[k], 32'h0);
            check(k, "t7 busy", busy[k], 1'b0);
            check(k, "t7 misaligned", mis[k], 1'b0);
            check(k, "t7 timeout", tout[k], 1'b0);
        end
        check(0, "t7 mem_req", bus0.mem_req, 1'b0);
        check(0, "t7 Cu_IR", bus0.Cu_IR, NOP);
        check(1, "t7 mem_addr", bus1.mem_addr, 32'h0);

        // randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            resetn      = ($urandom_range(0, 199) != 0);
            fetch_start = ($urandom_range(0, 2) == 0);
            pc_load     = ($urandom_range(0, 9) == 0);
            pc_in       = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
            mem_ack     = ($urandom_range(0, 2) == 0);
            mem_rdata   = $urandom;
            stall       = ($urandom_range(0, 2) == 0);
            ready       = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 4))
                0, 1:    inc = 32'd4;
                2:       inc = 32'd2;
                3:       inc = 32'hFFFF_FFF8;
                default: inc = $urandom;
            endcase
            tick(1);
        end

        resetn = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; mem_ack = 1'b0; ready = 1'b0;
        tick(2);
        chk = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
